// File: rtl/module_captura_numero.sv
// Keypad operand capture: accumulates up to N_DIGITS decimal digits with optional sign
// and hands the finished operand to the multiplier through a valid/ready handshake.
module module_captura_numero #(
  parameter int N_DIGITS = 2,
  parameter int WIDTH    = 7,
  parameter bit NEG_EN   = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tecla_valida_i,
  input  logic [1:0]                        tecla_codc_i,
  input  logic [1:0]                        tecla_codf_i,
  input  logic                              listo_i,
  output logic [WIDTH-1:0]                  numero_o,
  output logic                              signo_o,
  output logic                              valido_o,
  output logic [$clog2(N_DIGITS+1)-1:0]     digitos_o,
  output logic                              error_o
);

  localparam int    DW   = $clog2(N_DIGITS + 1);
  localparam int    EW   = WIDTH + 4;
  localparam longint MAXV = longint'(10 ** N_DIGITS) - 1;

  if (N_DIGITS < 1 || N_DIGITS > 4 || (longint'(1) << WIDTH) <= MAXV) begin : g_bad_params
    $error("module_captura_numero: WIDTH too small for N_DIGITS, or N_DIGITS out of 1..4");
  end

  typedef enum logic [1:0] {VACIO, CAPTURA, LISTO} estado_t;

  estado_t          r_estado;
  logic [WIDTH-1:0] r_numero;
  logic             r_signo;
  logic             r_valido;
  logic [DW-1:0]    r_digitos;
  logic             r_error;

  logic [3:0]       w_pos;
  logic             w_es_digito;
  logic [3:0]       w_digito;
  logic [EW-1:0]    w_siguiente;
  logic             w_borrar;
  logic             w_entrega;

  assign w_pos = {tecla_codc_i, tecla_codf_i};

  // Keypad position to decimal digit; non-digit positions are commands or unused.
  always_comb begin
    w_es_digito = 1'b1;
    w_digito    = 4'd0;
    case (w_pos)
      4'd0:    w_digito = 4'd1;
      4'd1:    w_digito = 4'd4;
      4'd2:    w_digito = 4'd7;
      4'd4:    w_digito = 4'd2;
      4'd5:    w_digito = 4'd5;
      4'd6:    w_digito = 4'd8;
      4'd7:    w_digito = 4'd0;
      4'd8:    w_digito = 4'd3;
      4'd9:    w_digito = 4'd6;
      4'd10:   w_digito = 4'd9;
      default: w_es_digito = 1'b0;
    endcase
  end

  assign w_siguiente = EW'(r_numero) * EW'(10) + EW'(w_digito);
  assign w_borrar    = tecla_valida_i && (w_pos == 4'd3);
  // Accepting edge: any key arriving in the same cycle is dropped.
  assign w_entrega   = r_valido && listo_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_estado  <= VACIO;
      r_numero  <= '0;
      r_signo   <= 1'b0;
      r_valido  <= 1'b0;
      r_digitos <= '0;
      r_error   <= 1'b0;
    end else begin
      r_error <= 1'b0;
      if (w_borrar || w_entrega) begin
        r_estado  <= VACIO;
        r_numero  <= '0;
        r_signo   <= 1'b0;
        r_valido  <= 1'b0;
        r_digitos <= '0;
      end else if (tecla_valida_i && r_estado != LISTO) begin
        if (w_es_digito) begin
          if (r_digitos < DW'(N_DIGITS)) begin
            r_numero  <= w_siguiente[WIDTH-1:0];
            r_digitos <= r_digitos + DW'(1);
            r_estado  <= CAPTURA;
          end else begin
            r_error <= 1'b1;
          end
        end else if (w_pos == 4'd12 && NEG_EN) begin
          r_signo <= ~r_signo;
        end else if (w_pos == 4'd11 && r_estado == CAPTURA) begin
          r_estado <= LISTO;
          r_valido <= 1'b1;
          if (r_numero == '0) r_signo <= 1'b0;
        end
      end
    end
  end

  assign numero_o  = r_numero;
  assign signo_o   = r_signo;
  assign valido_o  = r_valido;
  assign digitos_o = r_digitos;
  assign error_o   = r_error;

endmodule

// File: tb/tb_module_captura_numero.sv
// Scoreboard bench for module_captura_numero: a behavioural operand model predicts each
// cycle's outputs and every accepted operand; a monitor process compares them.
module tb_module_captura_numero;

  localparam int N   = 2;
  localparam int W   = 7;
  localparam bit NEG = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, kv, listo;
  logic [1:0]   codc, codf;
  logic [W-1:0] numero;
  logic         signo, valido, error;
  logic [1:0]   digitos;

  logic         rst4, kv4, listo4;
  logic [1:0]   codc4, codf4;
  logic [13:0]  numero4;
  logic         signo4, valido4, error4;
  logic [2:0]   digitos4;

  module_captura_numero #(.N_DIGITS(N), .WIDTH(W), .NEG_EN(NEG)) dut (
    .clk(clk), .rst(rst), .tecla_valida_i(kv), .tecla_codc_i(codc), .tecla_codf_i(codf),
    .listo_i(listo), .numero_o(numero), .signo_o(signo), .valido_o(valido),
    .digitos_o(digitos), .error_o(error));

  module_captura_numero #(.N_DIGITS(4), .WIDTH(14), .NEG_EN(1'b1)) dut4 (
    .clk(clk), .rst(rst4), .tecla_valida_i(kv4), .tecla_codc_i(codc4), .tecla_codf_i(codf4),
    .listo_i(listo4), .numero_o(numero4), .signo_o(signo4), .valido_o(valido4),
    .digitos_o(digitos4), .error_o(error4));

  typedef struct { int val; bit neg; bit vld; int digs; bit err; } exp_t;
  typedef struct { int val; bit neg; } xfer_t;
  exp_t  exp_q[$];
  xfer_t xf_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit running = 1'b0;

  // Operand model: a value, a digit count, a sign and a "presented" flag.
  int m_val = 0, m_digs = 0;
  bit m_neg = 1'b0, m_rdy = 1'b0;
  int dmap [16] = '{1, 4, 7, -1, 2, 5, 8, 0, 3, 6, 9, -1, -1, -1, -1, -1};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_val = 0; m_digs = 0; m_neg = 1'b0; m_rdy = 1'b0;
  endtask

  task automatic step(input int k, input int p, input int l, input int r = 1);
    bit    err;
    exp_t  e;
    xfer_t x;
    err = 1'b0;
    @(negedge clk);
    running = 1'b1;
    kv = (k != 0);
    {codc, codf} = 4'(p);
    listo = (l != 0);
    rst = (r != 0);
    if (r == 0) begin
      model_clear();
    end else begin
      if (m_rdy && l != 0) begin
        x.val = m_val; x.neg = m_neg;
        xf_q.push_back(x);
      end
      if ((k != 0 && p == 3) || (m_rdy && l != 0)) begin
        model_clear();
      end else if (k != 0 && !m_rdy) begin
        if (dmap[p] >= 0) begin
          if (m_digs < N) begin
            m_val = m_val * 10 + dmap[p];
            m_digs++;
          end else begin
            err = 1'b1;
          end
        end else if (p == 12 && NEG) begin
          m_neg = !m_neg;
        end else if (p == 11 && m_digs > 0) begin
          m_rdy = 1'b1;
          if (m_val == 0) m_neg = 1'b0;
        end
      end
    end
    e.val = m_val; e.neg = m_neg; e.vld = m_rdy; e.digs = m_digs; e.err = err;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected output set per clock, plus operand check on each accepting edge.
  initial begin : monitor
    bit    pv;
    bit    pn;
    int    pval;
    exp_t  e;
    xfer_t x;
    pv = 1'b0; pn = 1'b0; pval = 0;
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        if (pv && listo === 1'b1 && rst === 1'b1) begin
          n_cmp++;
          if (xf_q.size() == 0) begin
            n_bad++;
            $display("FAIL xfer_unexpected: got operand %0d expected no transfer", pval);
          end else begin
            x = xf_q.pop_front();
            n_cmp--;
            check("xfer_numero", 32'(pval), 32'(x.val));
            check("xfer_signo", 32'(pn), 32'(x.neg));
          end
        end
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard_empty: got output with no expectation, expected a queued entry");
        end else begin
          e = exp_q.pop_front();
          check("numero_o", 32'(numero), 32'(e.val));
          check("signo_o", 32'(signo), 32'(e.neg));
          check("valido_o", 32'(valido), 32'(e.vld));
          check("digitos_o", 32'(digitos), 32'(e.digs));
          check("error_o", 32'(error), 32'(e.err));
        end
      end
      pv = (valido === 1'b1); pn = (signo === 1'b1); pval = int'(numero);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst = 1'b0; kv = 1'b0; listo = 1'b0; codc = 2'd0; codf = 2'd0;
    rst4 = 1'b0; kv4 = 1'b0; listo4 = 1'b0; codc4 = 2'd0; codf4 = 2'd0;

    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 4, 0); step(1, 7, 0); step(1, 11, 0); step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);
    step(1, 12, 0); step(1, 10, 0); step(1, 0, 0); step(1, 11, 0);
    repeat (5) step(0, 0, 0);
    step(0, 0, 1); step(0, 0, 0);
    step(1, 2, 0); step(1, 8, 0); step(1, 6, 0); step(0, 0, 0); step(1, 3, 0);
    step(1, 12, 0); step(1, 7, 0); step(1, 11, 0); step(0, 0, 1); step(1, 11, 0); step(0, 0, 0);
    step(1, 5, 0); step(1, 5, 0); step(1, 11, 0); step(1, 0, 0); step(1, 12, 0);
    step(1, 3, 0); step(0, 0, 1);
    step(1, 9, 0); step(0, 0, 0, 0); step(0, 0, 0);
    step(1, 4, 1); step(1, 11, 1); step(1, 4, 1); step(1, 8, 1); step(1, 11, 1);
    step(1, 3, 1); step(0, 0, 0);
    step(1, 14, 0); step(1, 13, 0); step(1, 15, 0);

    repeat (400) begin
      step(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 99) != 0));
    end
    step(1, 3, 0); step(0, 0, 0);
    @(posedge clk);
    #2;
    running = 1'b0;
    check("xfer_pending", 32'(xf_q.size()), 32'd0);
    check("exp_pending", 32'(exp_q.size()), 32'd0);

    // Four-digit instance: 9999 fills it, a fifth digit is rejected.
    @(negedge clk); rst4 = 1'b0;
    @(negedge clk); rst4 = 1'b1; kv4 = 1'b1; {codc4, codf4} = 4'd10;
    repeat (3) @(negedge clk);
    @(negedge clk); kv4 = 1'b0;
    check("n4_numero", 32'(numero4), 32'd9999);
    check("n4_digitos", 32'(digitos4), 32'd4);
    kv4 = 1'b1; {codc4, codf4} = 4'd0;
    @(negedge clk); kv4 = 1'b0;
    check("n4_error", 32'(error4), 32'd1);
    check("n4_hold", 32'(numero4), 32'd9999);
    @(negedge clk);
    check("n4_error_pulse", 32'(error4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
